// File: rtl/video_timing_controller.sv
// rtl/video_timing_controller.sv - raster timing generator: h/v counters, syncs, data enable, pixel addresses (option: VTC_SYNC_ALIGN_EN)
module video_timing_controller #(
    parameter int   H_ACTIVE       = 1280,
    parameter int   H_FP           = 48,
    parameter int   H_SYNC         = 112,
    parameter int   H_BP           = 248,
    parameter int   V_ACTIVE       = 1024,
    parameter int   V_FP           = 1,
    parameter int   V_SYNC         = 3,
    parameter int   V_BP           = 38,
    parameter logic HS_POL         = 1'b1,
    parameter logic VS_POL         = 1'b1,
    parameter int   ROW_ADDR_WIDTH = 10,
    parameter int   COL_ADDR_WIDTH = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic                      next_pixel,
    output logic [ROW_ADDR_WIDTH-1:0] row_address,
    output logic [COL_ADDR_WIDTH-1:0] col_address,
    output logic                      frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VCW     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT_C  = HCW'(H_ACTIVE);
    localparam logic [VCW-1:0] V_ACT_C  = VCW'(V_ACTIVE);
    localparam logic [HCW-1:0] HS_START = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] VS_START = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    // run is low while in reset and for the release edge itself, so the first
    // cycle after release presents pixel (0,0) and every output is idle in reset.
    logic           run;

    logic active;
    logic hs_on;
    logic vs_on;
    logic hsync_d;
    logic vsync_d;
    logic de_d;

    // Track whether the raster is running (first edge with rst_n high starts it).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Free-running horizontal/vertical counters; held at 0 until running.
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Decode region, sync windows, addresses and frame marker from the counters.
    always_comb begin
        active      = run && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_on       = run && (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_on       = run && (v_cnt >= VS_START) && (v_cnt < VS_END);
        hsync_d     = hs_on ? HS_POL : ~HS_POL;
        vsync_d     = vs_on ? VS_POL : ~VS_POL;
        de_d        = active;
        next_pixel  = active;
        // Blanking addresses are forced to 0 so the last-pixel pair occurs once per frame.
        col_address = active ? COL_ADDR_WIDTH'(h_cnt) : '0;
        row_address = active ? ROW_ADDR_WIDTH'(v_cnt) : '0;
        frame_start = run && (h_cnt == '0) && (v_cnt == '0);
    end

`ifdef VTC_SYNC_ALIGN_EN
    // Delay syncs and de one clock to line up with downstream registered pixel data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            de    <= 1'b0;
        end else begin
            hsync <= hsync_d;
            vsync <= vsync_d;
            de    <= de_d;
        end
    end
`else
    // Syncs and de leave in the same cycle as the address.
    always_comb begin
        hsync = hsync_d;
        vsync = vsync_d;
        de    = de_d;
    end
`endif

endmodule

// File: tb/tb_video_timing_controller.sv
// tb/tb_video_timing_controller.sv - scoreboard bench for video_timing_controller with random reset stimulus
module tb_video_timing_controller;

    localparam int   HA = 16, HF = 3, HS = 4, HB = 5;
    localparam int   VA = 10, VF = 1, VS = 2, VB = 3;
    localparam bit   HP = 1'b0;
    localparam bit   VP = 1'b1;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   FRAME = HT * VT;
`ifdef VTC_SYNC_ALIGN_EN
    localparam bit   ALIGN = 1'b1;
`else
    localparam bit   ALIGN = 1'b0;
`endif

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        np;
        logic        fs;
        logic [9:0]  row;
        logic [10:0] col;
    } vid_t;

    typedef struct {
        int   t;
        vid_t o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync, vsync, de, next_pixel, frame_start;
    logic [9:0]  row_address;
    logic [10:0] col_address;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   t_now = -1;
    int   intervals = 0;
    bit   stim_done = 1'b0;

    video_timing_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP),
        .ROW_ADDR_WIDTH(10), .COL_ADDR_WIDTH(11)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hsync(hsync), .vsync(vsync), .de(de), .next_pixel(next_pixel),
        .row_address(row_address), .col_address(col_address),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // t = clocks since release (-1 in reset); ts = time the sync/de outputs reflect.
    function automatic vid_t model(int t, int ts);
        vid_t o;
        int   h, v;
        o = '0;
        o.hs = ~HP;
        o.vs = ~VP;
        if (t >= 0) begin
            h = t % HT;
            v = (t / HT) % VT;
            if (h < HA && v < VA) begin
                o.np  = 1'b1;
                o.row = 10'(v);
                o.col = 11'(h);
            end
            o.fs = (h == 0 && v == 0);
        end
        if (ts >= 0) begin
            h = ts % HT;
            v = (ts / HT) % VT;
            o.de = (h < HA && v < VA);
            o.hs = (h >= HA + HF && h < HA + HF + HS) ? HP : ~HP;
            o.vs = (v >= VA + VF && v < VA + VF + VS) ? VP : ~VP;
        end
        return o;
    endfunction

    // Drive rst_n for the next edge and queue what the DUT must show after it.
    task automatic drive(input bit r);
        exp_t e;
        int   t_prev;
        t_prev = t_now;
        t_now  = r ? t_now + 1 : -1;
        if (!r) t_now = -1;
        e.t = t_now;
        e.o = model(t_now, ALIGN ? (r ? t_prev : -1) : t_now);
        rst_n = r;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input bit r, input int n);
        for (int i = 0; i < n; i++) drive(r);
    endtask

    initial begin
        run_n(0, 3);
        run_n(1, 2 * FRAME + 50);
        run_n(0, 2);
        run_n(1, 5 * HT + 12 + 1);
        run_n(0, 5);
        run_n(1, FRAME + 5);
        for (int k = 0; k < 4; k++) begin
            run_n(0, $urandom_range(1, 4));
            run_n(1, $urandom_range(1, 500));
        end
        run_n(0, 1);
        run_n(1, 2 * FRAME + 3);
        stim_done = 1'b1;
    end

    // Monitor: one expected entry per clock; also frame period and last-pixel count.
    initial begin
        exp_t e;
        vid_t act;
        int   cyc = 0;
        int   last_fs = -1;
        int   lp_cnt = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {hsync, vsync, de, next_pixel, frame_start, row_address, col_address};
                total++;
                if (act !== e.o) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d t=%0d got hs%b vs%b de%b np%b fs%b r%0d c%0d want hs%b vs%b de%b np%b fs%b r%0d c%0d",
                             cyc, e.t, act.hs, act.vs, act.de, act.np, act.fs, act.row, act.col,
                             e.o.hs, e.o.vs, e.o.de, e.o.np, e.o.fs, e.o.row, e.o.col);
                end
                if (e.t < 0) begin
                    last_fs = -1;
                    lp_cnt  = 0;
                end else begin
                    if (frame_start === 1'b1) begin
                        if (last_fs >= 0) begin
                            total += 2;
                            intervals++;
                            if (cyc - last_fs != FRAME) begin
                                bad++;
                                $display("FAIL frame_period got %0d want %0d", cyc - last_fs, FRAME);
                            end
                            if (lp_cnt != 1) begin
                                bad++;
                                $display("FAIL last_pixel_count got %0d want 1", lp_cnt);
                            end
                        end
                        last_fs = cyc;
                        lp_cnt  = 0;
                    end
                    if (next_pixel === 1'b1 && row_address == 10'(VA - 1) && col_address == 11'(HA - 1))
                        lp_cnt++;
                end
                cyc++;
            end
        end
    end

    initial begin
        int guard;
        guard = 0;
        while (!stim_done && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #2;
        total++;
        if (!stim_done || q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d want 0", q.size());
        end
        total++;
        if (intervals < 4) begin
            bad++;
            $display("FAIL frame_intervals got %0d want >=4", intervals);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
